icache_line_fetcher: RTL and testbench
======================================

# icache_line_fetcher

Memory-side responder for instruction-cache line fills. Accepts a line request (one-cycle enable plus byte address) from the icache miss path, reads the 16 bytes of the aligned line from the byte-wide RAM port, and returns the assembled 128-bit line with a one-cycle done pulse. Sits between the icache and the memory arbiter. It stalls byte issue whenever the arbiter withholds the RAM port, and drops the fill on pipeline flush.

## Interface
- LINE_BYTES, 16, bytes per cache line; fixed by the icache geometry and not to be overridden.
- ADDR_W, 32, byte address width.
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  reset; synchronous and active-high.
- req_ena  in  1  line request from icache `mem_rd_ena`; may stay high for many cycles.
- req_addr  in  ADDR_W  request address from icache `mem_rd_addr`; bits 3:0 ignored.
- flush  in  1  pipeline flush; abandons any fill in progress.
- mem_gnt  in  1  arbiter grant; the RAM port belongs to this block only in cycles where it is 1.
- ram_a  out  ADDR_W  byte address to RAM; valid only in granted cycles.
- ram_din  in  8  RAM read data; byte for the address driven in cycle t appears in cycle t+1.
- busy  out  1  high from acceptance until the done cycle, inclusive.
- done  out  1  one-cycle pulse; line_data valid in that cycle (icache `mem_rd_done`).
- line_data  out  128  assembled line (icache `mem_rd_data`); byte k at bits 8k+7:8k.

## Operation
- States: IDLE, FETCH, DONE.
- IDLE: if req_ena=1 and flush=0, latch base = {req_addr[31:4], 4'b0}, clear counters and go to FETCH. busy rises next cycle.
- FETCH, issue side: issue counter `ic` runs 0..16. While ic<16 and mem_gnt=1, drive ram_a = base + ic and increment ic. While mem_gnt=0, hold ic and drive ram_a = 0.
- FETCH, receive side: a registered flag records that a byte was issued last cycle. When the flag is set, write ram_din into byte slot `rc` of the line register and increment rc. Receive proceeds even if mem_gnt has since dropped.
- When rc reaches 16, that is when the 16th byte has been written, go to DONE.
- DONE: done=1, line_data holds the full line, then return to IDLE. req_ena in the DONE cycle is ignored.
- req_ena while busy is ignored. The icache holds req_ena high for the whole miss, so repeated requests are normal and must not restart a fill.
- flush=1 in any state: go to IDLE next cycle, clear counters and the pending flag, and do not pulse done. A byte returning after a flush is discarded. flush has priority over req_ena in IDLE.
- Address arithmetic is modulo 2^ADDR_W. The line is aligned, so base+ic never crosses a line boundary.
- line_data holds its last value outside DONE. Consumers must sample it only in the done cycle.

## Timing
- Reset values: done=0, busy=0, ram_a=0, line_data=0, state=IDLE, ic=rc=0.
- With mem_gnt held at 1 and req_ena sampled in cycle 0:
  - ram_a = base+0..base+15 in cycles 1..16.
  - Bytes arrive in cycles 2..17.
  - done=1 in cycle 18.
- Each cycle with mem_gnt=0 during issue adds exactly one cycle of latency.
- A new request can be accepted in cycle 19, the first cycle after done.
- rst mid-fill has the same effect as reset: no done pulse, and a stale byte is discarded.

## Structure
- Shared `utils.v` already provides `ADDR_TP`, `WORD_TP`, `TRUE` and `FALSE`.
- Add `LINE_TP` (127:0) and `LINE_LN` (128) to `utils.v`, so the icache and this block share the line width. Add state encodings as local macros in this file.
- One optional sub-module, `line_assembler`: byte-slot write into a 128-bit register, indexed by rc. All FSM logic and counters stay in the top module.

## Test plan
- Basic fill: RAM[0x1000+k] = k+0xA0, req_addr=0x0000100C, gnt=1 → ram_a 0x1000..0x100F in cycles 1..16; done in cycle 18; line_data = 0xAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0.
- Sustained request: req_ena held high for 30 cycles → exactly one done in cycle 18 and a second fill accepted in cycle 19.
- Grant stall: gnt=0 in cycles 5..8 → ram_a=0 in those cycles, no duplicate or skipped address, done in cycle 22, same line contents.
- Flush: flush=1 in cycle 10 → IDLE in cycle 11 and no done pulse. A subsequent request to 0x2000 returns only 0x2000-line data, with no stale bytes.
- Reset mid-fill: rst in cycle 7 → all outputs zero next cycle and no done pulse.
- Wrap: req_addr=0xFFFFFFF4 → ram_a 0xFFFFFFF0..0xFFFFFFFF and done in cycle 18.

Source files
------------

// File: rtl/icache_line_fetcher_pkg.sv
// Shared types for the icache line fetcher.
// Line geometry, address type and FSM encoding.
package icache_line_fetcher_pkg;

   localparam int LINE_BYTES = 16;
   localparam int ADDR_W     = 32;
   localparam int LINE_LN    = 8 * LINE_BYTES;

   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [LINE_LN-1:0] line_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic addr_t line_base(addr_t a);
      return a & ~addr_t'(LINE_BYTES - 1);
   endfunction

endpackage

// File: rtl/icache_line_fetcher_if.sv
// Request, RAM port and line-return signals of the fetcher.
// master = icache/arbiter side, slave = fetcher.
interface icache_line_fetcher_if;
   import icache_line_fetcher_pkg::*;

   logic       req_ena;
   addr_t      req_addr;
   logic       flush;
   logic       mem_gnt;
   addr_t      ram_a;
   logic [7:0] ram_din;
   logic       busy;
   logic       done;
   line_t      line_data;

   modport master (
      output req_ena, req_addr, flush, mem_gnt, ram_din,
      input  ram_a, busy, done, line_data
   );

   modport slave (
      input  req_ena, req_addr, flush, mem_gnt, ram_din,
      output ram_a, busy, done, line_data
   );

endinterface

// File: rtl/icache_line_fetcher_line_assembler.sv
// Byte-slot writer into the 128-bit line register.
// Holds its value except when a slot write is requested.
module line_assembler
   import icache_line_fetcher_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [3:0] idx,
   input  logic [7:0] din,
   output line_t      line
);

   always_ff @(posedge clk) begin
      if (rst)
         line <= '0;
      else if (we)
         line[{idx, 3'b000} +: 8] <= din;
   end

endmodule

// File: rtl/icache_line_fetcher.sv
// Icache line-fill responder: issues 16 byte reads, assembles
// the line and pulses done; stalls on no-grant, aborts on flush.
module icache_line_fetcher
   import icache_line_fetcher_pkg::*;
(
   input logic                  clk,
   input logic                  rst,
   icache_line_fetcher_if.slave bus
);

   state_t     state;
   state_t     state_nx;
   addr_t      base;
   logic [4:0] ic;
   logic [4:0] rc;
   logic       pend;
   logic       acc;
   logic       issue;
   logic       wr;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      acc      = 1'b0;
      issue    = 1'b0;
      wr       = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.req_ena && !bus.flush) begin
               acc      = 1'b1;
               state_nx = FETCH;
            end
         end
         FETCH: begin
            issue = (ic < 5'd16) && bus.mem_gnt && !bus.flush;
            wr    = pend && !bus.flush;
            if (bus.flush)
               state_nx = IDLE;
            else if (wr && rc == 5'd15)
               state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // pend marks a byte issued last cycle; its data is on ram_din now
   always_ff @(posedge clk) begin
      if (rst) begin
         base <= '0;
         ic   <= '0;
         rc   <= '0;
         pend <= 1'b0;
      end else begin
         if (acc)
            base <= line_base(bus.req_addr);
         if (acc || bus.flush) begin
            ic   <= '0;
            rc   <= '0;
            pend <= 1'b0;
         end else begin
            if (issue)
               ic <= ic + 5'd1;
            if (wr)
               rc <= rc + 5'd1;
            pend <= issue;
         end
      end
   end

   assign bus.ram_a = issue ? base + addr_t'(ic[3:0]) : '0;
   assign bus.busy  = (state != IDLE);
   assign bus.done  = (state == DONE) && !bus.flush;

   line_assembler u_asm (
      .clk  (clk),
      .rst  (rst),
      .we   (wr),
      .idx  (rc[3:0]),
      .din  (bus.ram_din),
      .line (bus.line_data)
   );

endmodule

// File: tb/tb_icache_line_fetcher.sv
// Bench for icache_line_fetcher: vector table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_icache_line_fetcher;
   import icache_line_fetcher_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   icache_line_fetcher_if bus ();

   icache_line_fetcher dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   function automatic logic [7:0] mem(addr_t a);
      return (a[7:0] + 8'hA0) ^ (a[15:8] - 8'h10) ^ a[23:16] ^ a[31:24];
   endfunction

   function automatic line_t build_line(addr_t b);
      line_t l;
      for (int k = 0; k < 16; k++)
         l[8*k +: 8] = mem(b + addr_t'(k));
      return l;
   endfunction

   // byte-wide RAM with one cycle read latency
   always @(posedge clk) bus.ram_din <= mem(bus.ram_a);

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic r, addr_t a, logic f, logic g);
      bus.req_ena  = r;
      bus.req_addr = a;
      bus.flush    = f;
      bus.mem_gnt  = g;
   endtask

   typedef struct {
      addr_t req;
      int    s_lo;
      int    s_hi;
      int    done_cyc;
      line_t line;
   } vec_t;

   vec_t tbl[4];

   task automatic run_fill(vec_t v);
      addr_t b;
      addr_t ea;
      int    k;
      logic  g;
      b = v.req & 32'hFFFF_FFF0;
      k = 0;
      for (int c = 0; c <= v.done_cyc; c++) begin
         g = !(c >= v.s_lo && c <= v.s_hi);
         drive(1'b1, v.req, 1'b0, g);
         @(negedge clk);
         if (c >= 1 && k < 16 && g) begin
            ea = b + addr_t'(k);
            k++;
         end else begin
            ea = '0;
         end
         chk($sformatf("ram_a c%0d", c), bus.ram_a, ea);
         chk($sformatf("busy c%0d", c), bus.busy, c >= 1);
         chk($sformatf("done c%0d", c), bus.done, c == v.done_cyc);
         if (c == v.done_cyc)
            chk("line", bus.line_data, v.line);
         cyc();
      end
   endtask

   // reference model state
   int    m_st;
   addr_t m_base;
   int    m_iss;
   int    m_rcv;
   addr_t m_q[$];
   line_t m_line;

   initial begin
      logic  dn;
      logic  r_rst;
      logic  r_req;
      logic  r_fl;
      logic  r_g;
      addr_t r_a;
      logic  e_iss;
      addr_t e_a;
      addr_t pa;

      rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b1);
      cyc();
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("rst busy", bus.busy, 1'b0);
      chk("rst done", bus.done, 1'b0);
      chk("rst ram_a", bus.ram_a, '0);
      chk("rst line", bus.line_data, '0);
      cyc();

      tbl[0] = '{32'h0000_100C, -1, -1, 18,
                 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0};
      tbl[1] = '{32'h0000_100C, 5, 8, 22,
                 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0};
      tbl[2] = '{32'hFFFF_FFF4, -1, -1, 18, build_line(32'hFFFF_FFF0)};
      tbl[3] = '{32'h0000_2005, 3, 3, 19, build_line(32'h0000_2000)};
      for (int i = 0; i < 4; i++)
         run_fill(tbl[i]);
      drive(1'b0, '0, 1'b0, 1'b1);
      cyc();

      // flush in cycle 10 of a fill
      for (int c = 0; c < 10; c++) begin
         drive(1'b1, 32'h0000_1000, 1'b0, 1'b1);
         cyc();
      end
      drive(1'b0, '0, 1'b1, 1'b1);
      cyc();
      drive(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      chk("flush busy", bus.busy, 1'b0);
      chk("flush ram_a", bus.ram_a, '0);
      dn = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         dn = dn | bus.done;
         cyc();
      end
      chk("flush no done", dn, 1'b0);
      run_fill('{32'h0000_2000, -1, -1, 18, build_line(32'h0000_2000)});

      // reset in cycle 7 of a fill
      for (int c = 0; c < 7; c++) begin
         drive(1'b1, 32'h0000_3000, 1'b0, 1'b1);
         cyc();
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      chk("mrst busy", bus.busy, 1'b0);
      chk("mrst done", bus.done, 1'b0);
      chk("mrst ram_a", bus.ram_a, '0);
      chk("mrst line", bus.line_data, '0);
      dn = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         dn = dn | bus.done;
         cyc();
      end
      chk("mrst no done", dn, 1'b0);

      // randomized run against the model
      m_st  = 0;
      m_iss = 0;
      m_rcv = 0;
      m_q.delete();
      m_base = '0;
      m_line = '0;
      for (int n = 0; n < 3000; n++) begin
         r_rst = ($urandom_range(0, 199) == 0);
         r_fl  = ($urandom_range(0, 99) < 2);
         r_req = ($urandom_range(0, 1) == 1);
         r_g   = ($urandom_range(0, 3) != 0);
         r_a   = addr_t'($urandom);
         rst   = r_rst;
         drive(r_req, r_a, r_fl, r_g);
         @(negedge clk);
         e_iss = (m_st == 1) && (m_iss < 16) && r_g && !r_fl;
         e_a   = e_iss ? m_base + addr_t'(m_iss) : '0;
         chk("rnd ram_a", bus.ram_a, e_a);
         chk("rnd busy", bus.busy, m_st != 0);
         chk("rnd done", bus.done, (m_st == 2) && !r_fl);
         if (m_st == 2 && !r_fl)
            chk("rnd line", bus.line_data, m_line);
         if (r_rst) begin
            m_st  = 0;
            m_iss = 0;
            m_rcv = 0;
            m_q.delete();
         end else if (r_fl) begin
            m_st = 0;
            m_q.delete();
         end else if (m_st == 0) begin
            if (r_req) begin
               m_st   = 1;
               m_base = r_a & 32'hFFFF_FFF0;
               m_iss  = 0;
               m_rcv  = 0;
               m_q.delete();
            end
         end else if (m_st == 1) begin
            if (m_q.size() > 0) begin
               pa = m_q.pop_front();
               m_line[8*int'(pa - m_base) +: 8] = mem(pa);
               m_rcv++;
               if (m_rcv == 16)
                  m_st = 2;
            end
            if (e_iss) begin
               m_q.push_back(e_a);
               m_iss++;
            end
         end else begin
            m_st = 0;
         end
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
